// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: drives a dual-halfword read port and assembles 16/32-bit
// RV32IC instructions for decode over a valid/ready handshake, with redirects and faults.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [31:0]      mem_addr1,
    output logic [31:0]      mem_addr2,
    output logic             mem_renable,
    input  logic [15:0]      mem_rdata1,
    input  logic [15:0]      mem_rdata2,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [31:0]      instr,
    output logic [31:0]      instr_pc,
    output logic             instr_is_c,
    output logic             fetch_fault,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

    state_t           state_q, state_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic             resp_valid_q, resp_valid_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      req_pc;
    logic [31:0]      next_pc;
    logic             compressed;

    // Both halfwords arrive together, so a 32-bit instruction at pc%4==2 costs no extra cycle.
    assign compressed = (mem_rdata1[1:0] != 2'b11);
    assign next_pc    = resp_pc_q + (compressed ? 32'd2 : 32'd4);
    assign instr      = compressed ? {16'h0000, mem_rdata1} : {mem_rdata2, mem_rdata1};
    assign instr_pc   = resp_pc_q;
    assign instr_is_c = compressed;

    assign mem_addr1   = req_pc;
    assign mem_addr2   = req_pc + 32'd2;
    assign fetch_count = count_q;
    assign fetch_fault = rst_n ? fault_q : 1'b0;

    always_comb begin
        state_d      = state_q;
        resp_pc_d    = resp_pc_q;
        resp_valid_d = resp_valid_q;
        fault_d      = fault_q;
        count_d      = count_q;
        req_pc       = resp_pc_q;
        mem_renable  = 1'b0;
        instr_valid  = 1'b0;

        // Outputs are held at their reset values for as long as reset is asserted.
        if (!rst_n) begin
            req_pc = RESET_PC;
        end else if (redirect_valid) begin
            if (!redirect_pc[0]) begin
                req_pc       = redirect_pc;
                mem_renable  = 1'b1;
                state_d      = RUN;
                resp_pc_d    = redirect_pc;
                resp_valid_d = 1'b1;
                fault_d      = 1'b0;
            end else begin
                state_d      = FAULT;
                resp_valid_d = 1'b0;
                fault_d      = 1'b1;
            end
        end else begin
            case (state_q)
                BOOT: begin
                    req_pc       = RESET_PC;
                    mem_renable  = 1'b1;
                    state_d      = RUN;
                    resp_pc_d    = RESET_PC;
                    resp_valid_d = 1'b1;
                end
                RUN: begin
                    instr_valid = resp_valid_q;
                    if (!resp_valid_q) begin
                        mem_renable  = 1'b1;
                        resp_valid_d = 1'b1;
                    end else if (instr_ready) begin
                        req_pc      = next_pc;
                        mem_renable = 1'b1;
                        resp_pc_d   = next_pc;
                        count_d     = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                FAULT: begin
                    fault_d = 1'b1;
                end
                default: begin
                    state_d = BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= BOOT;
            resp_pc_q    <= RESET_PC;
            resp_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            resp_pc_q    <= resp_pc_d;
            resp_valid_q <= resp_valid_d;
            fault_q      <= fault_d;
            count_q      <= count_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a registered dual-halfword memory model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] mem_addr1, mem_addr2;
    logic        mem_renable;
    logic [15:0] mem_rdata1, mem_rdata2;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;
    logic        instr_is_c, fetch_fault;
    logic [3:0]  fetch_count;

    int ncmp = 0;
    int nfail = 0;

    logic [15:0] mem [0:1023];

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_addr1(mem_addr1), .mem_addr2(mem_addr2), .mem_renable(mem_renable),
        .mem_rdata1(mem_rdata1), .mem_rdata2(mem_rdata2),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .instr_is_c(instr_is_c),
        .fetch_fault(fetch_fault), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // Memory aliases a 2 KB window; read data only updates when enabled.
    always @(posedge clk) begin
        if (mem_renable) begin
            mem_rdata1 <= mem[mem_addr1[10:1]];
            mem_rdata2 <= mem[mem_addr2[10:1]];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_default();
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0001;
    endtask

    task automatic test_reset();
        fill_default();
        mem[0] = 16'h0013; mem[1] = 16'h0000; mem[2] = 16'h0013; mem[3] = 16'h0000;
        rst_n = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        #1;
        step();
        ncmp++; if (instr_valid !== 1'b0) begin nfail++; $display("FAIL rst_valid got %b exp 0", instr_valid); end
        ncmp++; if (mem_renable !== 1'b0) begin nfail++; $display("FAIL rst_renable got %b exp 0", mem_renable); end
        ncmp++; if (mem_addr1 !== 32'h0 || mem_addr2 !== 32'h2) begin nfail++; $display("FAIL rst_addr got %h/%h exp 0/2", mem_addr1, mem_addr2); end
        ncmp++; if (fetch_fault !== 1'b0 || fetch_count !== 4'd0) begin nfail++; $display("FAIL rst_state got fault %b cnt %0d exp 0/0", fetch_fault, fetch_count); end
        rst_n = 1'b1; #1;
        ncmp++; if (mem_renable !== 1'b1 || mem_addr1 !== 32'h0 || instr_valid !== 1'b0) begin nfail++; $display("FAIL boot got ren %b addr %h vld %b exp 1/0/0", mem_renable, mem_addr1, instr_valid); end
        instr_ready = 1'b1;
        step();
        ncmp++; if (instr_valid !== 1'b1 || instr !== 32'h0000_0013) begin nfail++; $display("FAIL first_instr got %b %h exp 1 00000013", instr_valid, instr); end
        ncmp++; if (instr_pc !== 32'h0 || instr_is_c !== 1'b0) begin nfail++; $display("FAIL first_pc got %h c=%b exp 0 c=0", instr_pc, instr_is_c); end
        ncmp++; if (mem_addr1 !== 32'h4 || mem_renable !== 1'b1) begin nfail++; $display("FAIL first_next got %h ren %b exp 4 1", mem_addr1, mem_renable); end
        step();
        ncmp++; if (instr_pc !== 32'h4 || fetch_count !== 4'd1) begin nfail++; $display("FAIL second got pc %h cnt %0d exp 4 1", instr_pc, fetch_count); end
    endtask

    task automatic test_mixed();
        rst_n = 1'b0;
        fill_default();
        mem[0] = 16'h4501; mem[1] = 16'h0593; mem[2] = 16'h00A0; mem[3] = 16'h0001; mem[4] = 16'h0085;
        step();
        rst_n = 1'b1; instr_ready = 1'b1; #1;
        step();
        ncmp++; if (instr !== 32'h0000_4501 || instr_pc !== 32'h0 || instr_is_c !== 1'b1) begin nfail++; $display("FAIL mix_c got %h pc %h c=%b exp 00004501 0 1", instr, instr_pc, instr_is_c); end
        ncmp++; if (mem_addr1 !== 32'h2) begin nfail++; $display("FAIL mix_next got %h exp 2", mem_addr1); end
        step();
        ncmp++; if (instr !== 32'h00A0_0593 || instr_pc !== 32'h2 || instr_is_c !== 1'b0) begin nfail++; $display("FAIL mix_32 got %h pc %h c=%b exp 00a00593 2 0", instr, instr_pc, instr_is_c); end
        ncmp++; if (mem_addr1 !== 32'h6 || mem_addr2 !== 32'h8) begin nfail++; $display("FAIL mix_next32 got %h/%h exp 6/8", mem_addr1, mem_addr2); end
        step();
        ncmp++; if (instr_pc !== 32'h6 || instr !== 32'h1 || fetch_count !== 4'd2) begin nfail++; $display("FAIL mix_third got pc %h instr %h cnt %0d exp 6 1 2", instr_pc, instr, fetch_count); end
    endtask

    task automatic test_stall();
        instr_ready = 1'b0; #1;
        ncmp++; if (mem_renable !== 1'b0 || mem_addr1 !== 32'h6 || instr_valid !== 1'b1) begin nfail++; $display("FAIL stall_req got ren %b addr %h vld %b exp 0 6 1", mem_renable, mem_addr1, instr_valid); end
        for (int i = 0; i < 3; i++) begin
            step();
            ncmp++; if (instr_pc !== 32'h6 || instr !== 32'h1 || fetch_count !== 4'd2 || mem_renable !== 1'b0) begin
                nfail++; $display("FAIL stall_hold%0d got pc %h instr %h cnt %0d ren %b exp 6 1 2 0", i, instr_pc, instr, fetch_count, mem_renable);
            end
        end
        instr_ready = 1'b1; #1;
        ncmp++; if (mem_addr1 !== 32'h8 || mem_renable !== 1'b1) begin nfail++; $display("FAIL resume_req got %h ren %b exp 8 1", mem_addr1, mem_renable); end
        step();
        ncmp++; if (instr_pc !== 32'h8 || instr !== 32'h85 || fetch_count !== 4'd3) begin nfail++; $display("FAIL resume got pc %h instr %h cnt %0d exp 8 85 3", instr_pc, instr, fetch_count); end
    endtask

    task automatic test_redirect();
        instr_ready = 1'b0; #1;
        redirect_valid = 1'b1; redirect_pc = 32'h100; instr_ready = 1'b1; #1;
        ncmp++; if (instr_valid !== 1'b0 || mem_addr1 !== 32'h100 || mem_addr2 !== 32'h102 || mem_renable !== 1'b1) begin
            nfail++; $display("FAIL redir_req got vld %b addr %h/%h ren %b exp 0 100/102 1", instr_valid, mem_addr1, mem_addr2, mem_renable);
        end
        step();
        redirect_valid = 1'b0; instr_ready = 1'b0; #1;
        ncmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== 32'h1) begin nfail++; $display("FAIL redir_resp got vld %b pc %h instr %h exp 1 100 1", instr_valid, instr_pc, instr); end
        ncmp++; if (fetch_count !== 4'd3) begin nfail++; $display("FAIL redir_cnt got %0d exp 3", fetch_count); end
    endtask

    task automatic test_fault();
        mem[10'h100] = 16'h1234;
        redirect_valid = 1'b1; redirect_pc = 32'h101; #1;
        ncmp++; if (instr_valid !== 1'b0 || mem_renable !== 1'b0) begin nfail++; $display("FAIL misalign_req got vld %b ren %b exp 0 0", instr_valid, mem_renable); end
        step();
        redirect_valid = 1'b0; #1;
        ncmp++; if (fetch_fault !== 1'b1 || instr_valid !== 1'b0 || mem_renable !== 1'b0) begin nfail++; $display("FAIL fault got f %b vld %b ren %b exp 1 0 0", fetch_fault, instr_valid, mem_renable); end
        step();
        ncmp++; if (fetch_fault !== 1'b1 || instr_valid !== 1'b0) begin nfail++; $display("FAIL fault_sticky got f %b vld %b exp 1 0", fetch_fault, instr_valid); end
        redirect_valid = 1'b1; redirect_pc = 32'h200; #1;
        ncmp++; if (mem_addr1 !== 32'h200 || mem_renable !== 1'b1) begin nfail++; $display("FAIL clear_req got %h ren %b exp 200 1", mem_addr1, mem_renable); end
        step();
        redirect_valid = 1'b0; #1;
        ncmp++; if (fetch_fault !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'h200 || instr !== 32'h1234) begin
            nfail++; $display("FAIL clear got f %b vld %b pc %h instr %h exp 0 1 200 1234", fetch_fault, instr_valid, instr_pc, instr);
        end
        ncmp++; if (fetch_count !== 4'd3) begin nfail++; $display("FAIL fault_cnt got %0d exp 3", fetch_count); end
    endtask

    task automatic test_wrap();
        mem[10'h3FF] = 16'h0013;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE; #1;
        ncmp++; if (mem_addr1 !== 32'hFFFF_FFFE || mem_addr2 !== 32'h0) begin nfail++; $display("FAIL wrap_addr got %h/%h exp fffffffe/0", mem_addr1, mem_addr2); end
        step();
        redirect_valid = 1'b0; #1;
        ncmp++; if (instr !== 32'h4501_0013 || instr_is_c !== 1'b0 || instr_pc !== 32'hFFFF_FFFE) begin nfail++; $display("FAIL wrap_instr got %h c=%b pc %h exp 45010013 0 fffffffe", instr, instr_is_c, instr_pc); end
        instr_ready = 1'b1; #1;
        ncmp++; if (mem_addr1 !== 32'h2) begin nfail++; $display("FAIL wrap_next got %h exp 2", mem_addr1); end
        step();
        ncmp++; if (instr_pc !== 32'h2 || fetch_count !== 4'd4) begin nfail++; $display("FAIL wrap_after got pc %h cnt %0d exp 2 4", instr_pc, fetch_count); end
    endtask

    task automatic test_reset_mid();
        instr_ready = 1'b1; rst_n = 1'b0; #1;
        ncmp++; if (instr_valid !== 1'b0 || mem_renable !== 1'b0 || mem_addr1 !== 32'h0 || mem_addr2 !== 32'h2) begin
            nfail++; $display("FAIL midrst_out got vld %b ren %b addr %h/%h exp 0 0 0/2", instr_valid, mem_renable, mem_addr1, mem_addr2);
        end
        step();
        ncmp++; if (fetch_count !== 4'd0 || fetch_fault !== 1'b0) begin nfail++; $display("FAIL midrst_state got cnt %0d f %b exp 0 0", fetch_count, fetch_fault); end
        rst_n = 1'b1; #1;
        ncmp++; if (mem_renable !== 1'b1 || mem_addr1 !== 32'h0 || instr_valid !== 1'b0) begin nfail++; $display("FAIL midrst_boot got ren %b addr %h vld %b exp 1 0 0", mem_renable, mem_addr1, instr_valid); end
        step();
        ncmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'h4501) begin nfail++; $display("FAIL midrst_first got vld %b pc %h instr %h exp 1 0 4501", instr_valid, instr_pc, instr); end
        for (int i = 0; i < 15; i++) step();
        ncmp++; if (fetch_count !== 4'd15) begin nfail++; $display("FAIL cnt_max got %0d exp 15", fetch_count); end
        step();
        ncmp++; if (fetch_count !== 4'd0) begin nfail++; $display("FAIL cnt_wrap got %0d exp 0", fetch_count); end
    endtask

    initial begin
        test_reset();
        test_mixed();
        test_stall();
        test_redirect();
        test_fault();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Initiator side of the dual-halfword instruction memory read port for the RV32IC(MF) core.
- Each cycle it drives a halfword address pair (pc, pc+2) and consumes the two 16-bit halfwords returned one cycle later.
- It assembles one 16-bit (compressed) or 32-bit instruction per transfer and hands it to decode over a valid/ready handshake.
- It also handles branch/jump redirects, downstream stalls and misaligned-target faults.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be halfword aligned.
- CNT_W, 32, width of the fetched-instruction counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- mem_addr1  out  32  byte address of first halfword (fetch pc)
- mem_addr2  out  32  byte address of second halfword (fetch pc+2)
- mem_renable  out  1  read enable; memory updates its read data only when high
- mem_rdata1  in  16  halfword at mem_addr1, registered by memory, valid 1 cycle after request
- mem_rdata2  in  16  halfword at mem_addr2, same timing as mem_rdata1
- redirect_valid  in  1  branch/jump/trap redirect request
- redirect_pc  in  32  redirect target byte address
- instr_valid  out  1  instr/instr_pc/instr_is_c are valid
- instr_ready  in  1  decode accepts the instruction this cycle
- instr  out  32  assembled instruction; compressed form zero-extended to {16'h0000, hw}
- instr_pc  out  32  byte address of instr
- instr_is_c  out  1  1 = 16-bit compressed instruction
- fetch_fault  out  1  misaligned redirect target; sticky until next aligned redirect
- fetch_count  out  CNT_W  number of accepted instructions; wraps modulo 2^CNT_W

Behaviour:
- Reset (clk edge with rst_n=0) sets:
  - state=BOOT, resp_pc=RESET_PC, resp_valid=0, fetch_count=0.
  - Outputs: fetch_fault=0, instr_valid=0, mem_renable=0, mem_addr1=RESET_PC, mem_addr2=RESET_PC+2.
- Reset mid-operation discards any in-flight response. Memory read data left over from before reset is never presented as valid.
- States:
  - BOOT: mem_renable=1, addr=RESET_PC. Next state RUN, resp_pc=RESET_PC, resp_valid=1.
  - RUN: instr_valid=resp_valid.
  - FAULT: instr_valid=0, mem_renable=0, fetch_fault=1.
- Decode of returned data in RUN (combinational from mem_rdata1/2):
  - compressed = (mem_rdata1[1:0] != 2'b11).
  - instr = compressed ? {16'h0, mem_rdata1} : {mem_rdata2, mem_rdata1}.
  - next_pc = resp_pc + (compressed ? 2 : 4), modulo 2^32.
  - instr_pc=resp_pc, instr_is_c=compressed.
- Handshake in RUN: outputs stay stable while instr_valid=1 and instr_ready=0.
  - Transfer (instr_valid & instr_ready):
    - mem_addr1=next_pc, mem_addr2=next_pc+2, mem_renable=1 in the same cycle.
    - Next edge: resp_pc<=next_pc, fetch_count+1.
    - Sustained throughput is 1 instruction/cycle; latency from request to instr_valid is 1 cycle.
  - Stall (instr_valid & !instr_ready):
    - mem_renable=0 so the memory holds its rdata.
    - mem_addr1/2 keep showing resp_pc/resp_pc+2.
    - Nothing in the block changes.
- A 32-bit instruction at any halfword-aligned pc, including pc%4==2, needs no extra cycle because both halfwords arrive together.
- Redirect (redirect_valid=1) has the highest priority after reset and applies in any state.
  - Aligned target (redirect_pc[0]=0):
    - Same cycle: mem_addr1=redirect_pc, mem_addr2=redirect_pc+2, mem_renable=1, instr_valid forced 0 (no transfer, no count).
    - Next edge: state=RUN, resp_pc=redirect_pc, resp_valid=1, fetch_fault=0.
  - Misaligned target (redirect_pc[0]=1):
    - Same cycle: mem_renable=0, instr_valid=0.
    - Next edge: state=FAULT, resp_valid=0, fetch_fault=1.
  - A redirect in the same cycle as instr_ready=1 wins; the current instruction is not accepted.
- Address arithmetic wraps at 2^32 (pc=32'hFFFF_FFFE gives mem_addr2=32'h0000_0000).
- Out-of-range addresses are not checked; the memory aliases them.
- fetch_count wraps from all-ones to 0.

Test Plan:
- Reset then release, memory holding 0x00000013 (addi) at 0x0 and 0x4: BOOT issues addr1=0x0, addr2=0x2. Next cycle instr_valid=1, instr=0x00000013, instr_pc=0, instr_is_c=0; with ready=1 the next request is addr1=0x4.
- Mixed stream of a compressed 0x4501 at 0x0 followed by a 32-bit 0x00A00593 at 0x2: outputs are instr=0x00004501 (pc 0, is_c=1), then instr=0x00A00593 (pc 2, is_c=0), then pc 6. Each is delivered on consecutive cycles.
- Hold instr_ready=0 for 3 cycles mid-stream: mem_renable=0 and instr/instr_pc stay constant, fetch_count unchanged. Raising ready resumes at next_pc with no duplicate or skipped instruction.
- Assert redirect_valid with redirect_pc=0x100 while stalled: that cycle has instr_valid=0 and addr1=0x100. Next cycle instr_pc=0x100 and fetch_count is not incremented for the dropped instruction.
- Assert redirect_pc=0x101: fetch_fault=1, instr_valid stays 0, mem_renable=0. A subsequent redirect to 0x200 clears fault and fetching resumes at 0x200.
- Drive rst_n=0 for one edge mid-stream with ready=1: outputs return to reset values, fetch_count=0, and fetching restarts at RESET_PC through BOOT.
